pipe_flow_ctrl: RTL and testbench
=================================

Name: pipe_flow_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB).
- Owns the per-stage valid bits and generates all inter-stage register enables, bubbles and flushes.
- Inputs are the hazard unit's load-use request, multi-cycle busy signals from EXU/LSU, EX branch redirect, and ID drain requests (fence.i/CSR).
- Also keeps saturating retire and bubble performance counters.

Parameters:
- CNT_W, 32, width of the retire and bubble counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- if_inst_valid  in  1  IFU presents a fetched instruction this cycle.
- load_use  in  1  hazard unit: ID instruction needs the EX load result.
- ex_busy  in  1  EX multi-cycle op (mul/div) not finished.
- lsu_busy  in  1  MEM access outstanding.
- redirect  in  1  EX branch/jump mispredict; held by the EXU until accepted.
- drain_req  in  1  ID instruction requires an empty EX/MEM/WB before issue.
- pc_en  out  1  PC register update enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- id_flush  out  1  squash IF/ID contents (redirect accepted).
- id_valid, ex_valid, mem_valid, wb_valid  out  1 each  registered stage valid bits.
- retire_cnt  out  CNT_W  WB retirements, saturating.
- bubble_cnt  out  CNT_W  bubbles injected into EX, saturating.

Behaviour:
- Reset (async, rst_n=0): all valid bits 0, FSM=RUN, both counters 0. All outputs are functions of these registers plus inputs; no output is X during reset.
- Stall chain (combinational, back-to-front):
  - mem_stall = mem_valid & lsu_busy.
  - ex_stall = (ex_valid & ex_busy) | mem_stall.
  - hold_id = id_valid & (load_use | drain_hold).
  - id_stall = ex_stall | hold_id.
- redir_ok = redirect & ex_valid & ~ex_stall. A redirect arriving while EX is stalled is ignored; the EXU keeps it asserted until accepted.
- Enables:
  - mem_wb_en = ~mem_stall.
  - ex_mem_en = id_ex_en = ~ex_stall.
  - if_id_en = pc_en = ~id_stall | redir_ok.
  - id_flush = redir_ok.
- Valid update each posedge:
  - wb_valid <= mem_valid & ~mem_stall.
  - mem_valid <= mem_stall ? 1 : (ex_valid & ~ex_stall). An EX stall with MEM free inserts a MEM bubble.
  - ex_valid <= ex_stall ? ex_valid : (id_valid & ~hold_id & ~redir_ok).
  - id_valid <= redir_ok ? 0 : (id_stall ? id_valid : if_inst_valid).
- Priority: redir_ok beats load_use/drain. The branch in EX is older, so the stalled ID instruction is the wrong path and is killed.
- Drain FSM (drain_hold = state!=RELEASE & drain_req):
  - RUN -> DRAIN when id_valid & drain_req & ~redir_ok.
  - DRAIN: ID held. Go to RELEASE when ex_valid, mem_valid and wb_valid are all 0 at the cycle start. Go to RUN if redir_ok.
  - RELEASE: drain_hold=0 for exactly one cycle. ID advances if ~ex_stall (always true when empty) and ~load_use. Then RUN.
  - drain_req deasserted in DRAIN -> RUN next cycle.
- Counters:
  - retire_cnt += 1 when wb_valid.
  - bubble_cnt += 1 when ~ex_stall and the next ex_valid is 0 because of hold_id or redir_ok with id_valid=1.
  - Both saturate at all-ones; no wrap.
- Simultaneous lsu_busy and ex_busy: MEM holds, EX holds, no bubble is created.
- Reset mid-operation: all in-flight valids are dropped immediately (async).

Test Plan:
- Free-flow: rst_n release, if_inst_valid=1 for 10 cycles, no hazards -> wb_valid first high at cycle 5; all enables 1; retire_cnt=6 after cycle 10; bubble_cnt=0.
- Load-use: load_use=1 for one cycle with id_valid=1 -> pc_en=if_id_en=0 that cycle, next ex_valid=0, ID instruction issues a cycle later, bubble_cnt=1.
- LSU wait: lsu_busy=1 for 3 cycles with mem_valid=1 -> mem_wb_en=ex_mem_en=id_ex_en=pc_en=0 for 3 cycles; wb_valid=0 for 3 cycles; no instruction lost or duplicated (retire count matches issue count).
- Redirect while load_use: redirect=1 with ex_valid=1, load_use=1 -> id_flush=1, pc_en=1, next id_valid=0, ex_valid=0, bubble_cnt+1.
- Redirect during ex_busy: redirect and ex_busy high 4 cycles -> id_flush=0 throughout; id_flush=1 in the first cycle ex_busy=0.
- Drain: drain_req at ID with 3 older instructions in flight -> ID held until ex/mem/wb all 0, one RELEASE cycle, ID issues, FSM back to RUN; rst_n pulse mid-DRAIN -> all valids 0, FSM RUN.

Source files
------------

// File: rtl/pipe_flow_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage valid bits, inter-stage enables,
// bubble/flush generation, a drain FSM for serialising ID instructions, and perf counters.
module pipe_flow_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_inst_valid,
    input  logic             load_use,
    input  logic             ex_busy,
    input  logic             lsu_busy,
    input  logic             redirect,
    input  logic             drain_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             id_flush,
    output logic             id_valid,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_id_valid;
    logic             r_ex_valid;
    logic             r_mem_valid;
    logic             r_wb_valid;
    logic [CNT_W-1:0] r_retire_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_drain_hold;
    logic w_mem_stall;
    logic w_ex_stall;
    logic w_hold_id;
    logic w_id_stall;
    logic w_redir_ok;
    logic w_back_empty;
    logic w_bubble_inc;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_drain_hold = (r_state != ST_RELEASE) & drain_req;
    assign w_mem_stall  = r_mem_valid & lsu_busy;
    assign w_ex_stall   = (r_ex_valid & ex_busy) | w_mem_stall;
    assign w_hold_id    = r_id_valid & (load_use | w_drain_hold);
    assign w_id_stall   = w_ex_stall | w_hold_id;
    // A redirect is only taken once EX can move; the EXU keeps it asserted until then.
    assign w_redir_ok   = redirect & r_ex_valid & ~w_ex_stall;
    assign w_back_empty = ~(r_ex_valid | r_mem_valid | r_wb_valid);
    assign w_bubble_inc = ~w_ex_stall & r_id_valid & (w_hold_id | w_redir_ok);

    assign mem_wb_en  = ~w_mem_stall;
    assign ex_mem_en  = ~w_ex_stall;
    assign id_ex_en   = ~w_ex_stall;
    assign if_id_en   = ~w_id_stall | w_redir_ok;
    assign pc_en      = ~w_id_stall | w_redir_ok;
    assign id_flush   = w_redir_ok;
    assign id_valid   = r_id_valid;
    assign ex_valid   = r_ex_valid;
    assign mem_valid  = r_mem_valid;
    assign wb_valid   = r_wb_valid;
    assign retire_cnt = r_retire_cnt;
    assign bubble_cnt = r_bubble_cnt;

    // Stage valid bits; an EX stall with MEM free drops a bubble into MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid  <= 1'b0;
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else begin
            r_wb_valid  <= r_mem_valid & ~w_mem_stall;
            r_mem_valid <= w_mem_stall ? 1'b1 : (r_ex_valid & ~w_ex_stall);
            r_ex_valid  <= w_ex_stall ? r_ex_valid : (r_id_valid & ~w_hold_id & ~w_redir_ok);
            r_id_valid  <= w_redir_ok ? 1'b0 : (w_id_stall ? r_id_valid : if_inst_valid);
        end
    end

    // Drain FSM: hold ID until EX/MEM/WB are empty, then open a one-cycle issue window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_id_valid & drain_req & ~w_redir_ok) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (w_redir_ok | ~drain_req) begin
                        r_state <= ST_RUN;
                    end else if (w_back_empty) begin
                        r_state <= ST_RELEASE;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_RELEASE: r_state <= ST_RUN;
                default:    r_state <= ST_RUN;
            endcase
        end
    end

    // Saturating retire and EX-bubble performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= {CNT_W{1'b0}};
            r_bubble_cnt <= {CNT_W{1'b0}};
        end else begin
            if (r_wb_valid) begin
                r_retire_cnt <= sat_inc(r_retire_cnt);
            end else begin
                r_retire_cnt <= r_retire_cnt;
            end
            if (w_bubble_inc) begin
                r_bubble_cnt <= sat_inc(r_bubble_cnt);
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed-vector bench for pipe_flow_ctrl with hand-computed expectations.
module tb_pipe_flow_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             if_inst_valid;
    logic             load_use;
    logic             ex_busy;
    logic             lsu_busy;
    logic             redirect;
    logic             drain_req;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             id_flush;
    logic             id_valid;
    logic             ex_valid;
    logic             mem_valid;
    logic             wb_valid;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

    logic [5:0] w_en;
    logic [3:0] w_vld;
    logic [3:0] drain_vld [4];

    assign w_en  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_flush};
    assign w_vld = {id_valid, ex_valid, mem_valid, wb_valid};

    pipe_flow_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_inst_valid (if_inst_valid),
        .load_use      (load_use),
        .ex_busy       (ex_busy),
        .lsu_busy      (lsu_busy),
        .redirect      (redirect),
        .drain_req     (drain_req),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_en     (mem_wb_en),
        .id_flush      (id_flush),
        .id_valid      (id_valid),
        .ex_valid      (ex_valid),
        .mem_valid     (mem_valid),
        .wb_valid      (wb_valid),
        .retire_cnt    (retire_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic lu, input logic eb,
                         input logic lb, input logic rd, input logic dr);
        if_inst_valid = iv;
        load_use      = lu;
        ex_busy       = eb;
        lsu_busy      = lb;
        redirect      = rd;
        drain_req     = dr;
        #1;
    endtask

    task automatic run(input int n);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drain_vld[0] = 4'b1111;
        drain_vld[1] = 4'b1011;
        drain_vld[2] = 4'b1001;
        drain_vld[3] = 4'b1000;

        // Reset state and free flow
        do_reset();
        check_val("rst_valids", {28'd0, w_vld}, 32'd0);
        check_val("rst_retire", {28'd0, retire_cnt}, 32'd0);
        check_val("rst_bubble", {28'd0, bubble_cnt}, 32'd0);
        check_val("rst_en", {26'd0, w_en}, {26'd0, 6'b111110});
        for (int c = 1; c <= 10; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_val("ff_en", {26'd0, w_en}, {26'd0, 6'b111110});
            check_val("ff_wb", {31'd0, wb_valid}, (c >= 5) ? 32'd1 : 32'd0);
            cyc();
        end
        check_val("ff_retire6", {28'd0, retire_cnt}, 32'd6);
        check_val("ff_bubble0", {28'd0, bubble_cnt}, 32'd0);
        run(4);
        check_val("ff_retire10", {28'd0, retire_cnt}, 32'd10);
        check_val("ff_empty", {28'd0, w_vld}, 32'd0);

        // Saturation of both counters
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        check_val("sat_retire", {28'd0, retire_cnt}, 32'd15);
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
            if (c == 4) check_val("sat_bubble5", {28'd0, bubble_cnt}, 32'd5);
        end
        check_val("sat_bubble", {28'd0, bubble_cnt}, 32'd15);
        check_val("sat_retire_hold", {28'd0, retire_cnt}, 32'd15);

        // Load-use bubble
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("lu_en", {26'd0, w_en}, {26'd0, 6'b001110});
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("lu_vld1", {28'd0, w_vld}, {28'd0, 4'b1010});
        check_val("lu_bubble", {28'd0, bubble_cnt}, 32'd1);
        cyc();
        check_val("lu_vld2", {28'd0, w_vld}, {28'd0, 4'b0101});
        run(5);
        check_val("lu_retire", {28'd0, retire_cnt}, 32'd2);

        // LSU wait
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check_val("lsu_en", {26'd0, w_en}, 32'd0);
            check_val("lsu_wb", {31'd0, wb_valid}, 32'd0);
            check_val("lsu_mem", {31'd0, mem_valid}, 32'd1);
            cyc();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("lsu_vld", {28'd0, w_vld}, {28'd0, 4'b1110});
        run(6);
        check_val("lsu_retire", {28'd0, retire_cnt}, 32'd3);
        check_val("lsu_empty", {28'd0, w_vld}, 32'd0);
        check_val("lsu_bubble", {28'd0, bubble_cnt}, 32'd0);

        // Redirect beats load-use
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("rlu_en", {26'd0, w_en}, {26'd0, 6'b111111});
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rlu_vld", {28'd0, w_vld}, {28'd0, 4'b0010});
        check_val("rlu_bubble", {28'd0, bubble_cnt}, 32'd1);
        run(4);
        check_val("rlu_retire", {28'd0, retire_cnt}, 32'd1);

        // Redirect held while EX busy
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            check_val("rbusy_en", {26'd0, w_en}, {26'd0, 6'b000010});
            check_val("rbusy_ex", {31'd0, ex_valid}, 32'd1);
            cyc();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("rbusy_flush", {26'd0, w_en}, {26'd0, 6'b111111});
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rbusy_vld", {28'd0, w_vld}, {28'd0, 4'b0010});
        check_val("rbusy_bubble", {28'd0, bubble_cnt}, 32'd1);

        // Drain with three older instructions in flight
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_val("drn_en", {26'd0, w_en}, {26'd0, 6'b001110});
            check_val("drn_vld", {28'd0, w_vld}, {28'd0, drain_vld[c]});
            cyc();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("drn_release_en", {26'd0, w_en}, {26'd0, 6'b111110});
        check_val("drn_bubble", {28'd0, bubble_cnt}, 32'd4);
        check_val("drn_retire", {28'd0, retire_cnt}, 32'd3);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("drn_issue", {28'd0, w_vld}, {28'd0, 4'b1100});
        run(5);
        check_val("drn_retire_all", {28'd0, retire_cnt}, 32'd5);
        check_val("drn_bubble_end", {28'd0, bubble_cnt}, 32'd4);

        // Asynchronous reset in the middle of a drain
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("mrst_pre", {28'd0, w_vld}, {28'd0, 4'b1010});
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst_vld", {28'd0, w_vld}, 32'd0);
        check_val("mrst_bubble", {28'd0, bubble_cnt}, 32'd0);
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("mrst_run_hold", {31'd0, pc_en}, 32'd0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("mrst_drain_hold", {31'd0, pc_en}, 32'd0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("mrst_release", {31'd0, pc_en}, 32'd1);
        cyc();
        check_val("mrst_issue", {28'd0, w_vld}, {28'd0, 4'b0100});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
